// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped read-only instruction cache with 4-word line refill and saturating miss counter
module icache_ctrl #(
   parameter int NUM_BLOCKS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         proc_read,
   input  logic [29:0]  proc_addr,
   output logic [31:0]  proc_rdata,
   output logic         Icache_Stall,
   output logic         mem_read,
   output logic [27:0]  mem_addr,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready,
   output logic [15:0]  miss_cnt
);
   localparam int IW = $clog2(NUM_BLOCKS);
   localparam int TW = 28 - IW;
   typedef enum logic {IDLE, FETCH} state_t;
   state_t                state_q, state_d;
   logic [NUM_BLOCKS-1:0] valid_q, valid_d;
   logic [TW-1:0]         tag_q  [NUM_BLOCKS];
   logic [TW-1:0]         tag_d  [NUM_BLOCKS];
   logic [127:0]          data_q [NUM_BLOCKS];
   logic [127:0]          data_d [NUM_BLOCKS];
   logic [27:0]           mem_addr_q, mem_addr_d;
   logic [15:0]           miss_cnt_q, miss_cnt_d;
   logic [IW-1:0]         idx, widx;
   logic [TW-1:0]         tag;
   logic                  hit, refill;

   assign idx          = proc_addr[IW+1:2];
   assign tag          = proc_addr[29:IW+2];
   assign widx         = mem_addr_q[IW-1:0];
   assign hit          = valid_q[idx] && tag_q[idx] == tag;
   assign refill       = state_q == FETCH && mem_ready;
   assign proc_rdata   = data_q[idx][{proc_addr[1:0], 5'd0} +: 32];
   assign mem_read     = state_q == FETCH;
   assign Icache_Stall = mem_read || (proc_read && !hit);
   assign mem_addr     = mem_addr_q;
   assign miss_cnt     = miss_cnt_q;

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      data_d     = data_q;
      mem_addr_d = mem_addr_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == IDLE && proc_read && !hit) begin
         state_d    = FETCH;
         mem_addr_d = proc_addr[29:2];
         miss_cnt_d = miss_cnt_q + {15'd0, ~&miss_cnt_q};
      end
      // the refill target comes from the latched line address, not the live request
      if (refill) begin
         state_d       = IDLE;
         valid_d[widx] = 1'b1;
         tag_d[widx]   = mem_addr_q[27:IW];
         data_d[widx]  = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         mem_addr_q <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         mem_addr_q <= mem_addr_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed self-checking bench for icache_ctrl
module tb_icache_ctrl;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         proc_read;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_rdata;
   logic         Icache_Stall;
   logic         mem_read;
   logic [27:0]  mem_addr;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic [15:0]  miss_cnt;
   int           errors = 0;
   int           checks = 0;

   localparam logic [127:0] L0 = 128'h33333333_22222222_11111111_00000000;
   localparam logic [127:0] L1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] L2 = 128'h89ABCDEF_01234567_FEEDF00D_CAFEBABE;

   icache_ctrl #(.NUM_BLOCKS(8)) dut (
      .clk(clk), .rst_n(rst_n), .proc_read(proc_read), .proc_addr(proc_addr),
      .proc_rdata(proc_rdata), .Icache_Stall(Icache_Stall), .mem_read(mem_read),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [127:0] l, input logic [1:0] w);
      logic [127:0] s;
      s = l >> (32 * w);
      return s[31:0];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      proc_read = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // miss on a, memory answers after k FETCH cycles, then the same address must hit
   task automatic do_miss(input logic [29:0] a, input logic [127:0] line, input int k, input logic [15:0] cnt);
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = a;
      mem_ready = 1'b0;
      #1 chk("miss_stall", Icache_Stall, 1);
      chk("miss_no_memread", mem_read, 0);
      for (int i = 1; i <= k; i++) begin
         @(negedge clk);
         mem_ready = (i == k);
         mem_rdata = line;
         #1 chk("fetch_memread", mem_read, 1);
         chk("fetch_addr", mem_addr, a[29:2]);
         chk("fetch_stall", Icache_Stall, 1);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1 chk("refill_stall", Icache_Stall, 0);
      chk("refill_data", proc_rdata, word_of(line, a[1:0]));
      chk("refill_memread", mem_read, 0);
      chk("miss_cnt", miss_cnt, cnt);
   endtask

   initial begin
      rst_n = 1'b0;
      proc_read = 1'b0;
      proc_addr = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      #2 chk("rst_stall", Icache_Stall, 0);
      chk("rst_memread", mem_read, 0);
      chk("rst_memaddr", mem_addr, 0);
      chk("rst_misscnt", miss_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_miss(30'h10, L0, 3, 16'd1);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         proc_addr = 30'h10 + 30'(i);
         #1 chk("hit_stall", Icache_Stall, 0);
         chk("hit_data", proc_rdata, word_of(L0, 2'(i)));
         chk("hit_misscnt", miss_cnt, 1);
      end

      do_reset();
      do_miss(30'h10, L0, 1, 16'd1);
      do_miss(30'h30, L1, 2, 16'd2);
      do_miss(30'h10, L0, 1, 16'd3);

      do_reset();
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = 30'h10;
      #1 chk("chg_miss_stall", Icache_Stall, 1);
      @(negedge clk);
      proc_addr = 30'h50;
      #1 chk("chg_memaddr", mem_addr, 28'h4);
      chk("chg_memread", mem_read, 1);
      chk("chg_stall", Icache_Stall, 1);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = L0;
      #1 chk("chg_memaddr_hold", mem_addr, 28'h4);
      @(negedge clk);
      mem_ready = 1'b0;
      proc_addr = 30'h12;
      #1 chk("chg_line4_stall", Icache_Stall, 0);
      chk("chg_line4_data", proc_rdata, 32'h22222222);
      proc_addr = 30'h50;
      #1 chk("chg_new_miss", Icache_Stall, 1);
      chk("chg_idle_memread", mem_read, 0);
      @(negedge clk);
      #1 chk("chg_new_memaddr", mem_addr, 28'h14);
      chk("chg_new_memread", mem_read, 1);
      chk("chg_misscnt", miss_cnt, 2);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = L2;
      @(negedge clk);
      mem_ready = 1'b0;
      #1 chk("chg_new_stall", Icache_Stall, 0);
      chk("chg_new_data", proc_rdata, word_of(L2, 2'd0));

      do_reset();
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = 30'h10;
      @(negedge clk);
      @(negedge clk);
      #1 chk("rmid_memread", mem_read, 1);
      rst_n = 1'b0;
      #1 chk("rmid_memread_drop", mem_read, 0);
      chk("rmid_misscnt", miss_cnt, 0);
      chk("rmid_memaddr", mem_addr, 0);
      proc_read = 1'b0;
      #1 chk("rmid_stall", Icache_Stall, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = L1;
      @(negedge clk);
      mem_ready = 1'b0;
      #1 chk("rmid_ignored_memread", mem_read, 0);
      chk("rmid_ignored_cnt", miss_cnt, 0);
      proc_read = 1'b1;
      proc_addr = 30'h0;
      #1 chk("rmid_line0_miss", Icache_Stall, 1);
      proc_read = 1'b0;
      do_miss(30'h10, L0, 1, 16'd1);

      // preload the counter near its ceiling so saturation is reached in a few misses
      @(negedge clk);
      proc_read = 1'b0;
      force dut.miss_cnt_q = 16'hFFFC;
      #1 release dut.miss_cnt_q;
      #1 chk("sat_preload", miss_cnt, 16'hFFFC);
      do_miss(30'h30, L1, 1, 16'hFFFD);
      do_miss(30'h10, L0, 1, 16'hFFFE);
      do_miss(30'h30, L1, 1, 16'hFFFF);
      do_miss(30'h10, L0, 1, 16'hFFFF);
      do_miss(30'h30, L1, 1, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
